// File: rtl/console_writer_if.sv
// Character stream in, VRAM write port and cursor out, for the console VRAM writer.
// The writer takes the slave side; the character source / VRAM side takes master.
interface console_writer_if;
    logic [7:0]  char_i;
    logic        char_valid;
    logic        char_ready;
    logic        we_vram;
    logic [12:0] addr_vram;
    logic [7:0]  data_vram;
    logic [9:0]  cursor_x;
    logic [9:0]  cursor_y;

    modport master (
        output char_i, char_valid,
        input  char_ready, we_vram, addr_vram, data_vram, cursor_x, cursor_y
    );

    modport slave (
        input  char_i, char_valid,
        output char_ready, we_vram, addr_vram, data_vram, cursor_x, cursor_y
    );
endinterface

// File: rtl/console_writer.sv
// Text-console VRAM writer: cursor tracking, printable/control code handling, screen and line blanking.
// Latency: write strobe, address, data and cursor are registered, one cycle after the accept edge.
// Backpressure: char_ready is high only in IDLE; a held character waits through CLEAR/CLRLINE.
module console_writer #(
    parameter int size    = 16,
    parameter int screenW = 640 / size,
    parameter int screenH = 480 / size
) (
    input  logic             px_clk,
    input  logic             rst_n,
    console_writer_if.slave  bus
);

    localparam logic [9:0]  X_LAST    = 10'(screenW - 1);
    localparam logic [9:0]  Y_LAST    = 10'(screenH - 1);
    localparam logic [12:0] ROW_W     = 13'(screenW);
    localparam logic [12:0] LINE_LAST = 13'(screenW - 1);
    localparam logic [12:0] CELL_LAST = 13'(screenW * screenH - 1);

    localparam logic [7:0] CH_BLANK = 8'h20;
    localparam logic [7:0] CH_TILDE = 8'h7E;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_FF    = 8'h0C;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_CLRLINE
    } state_t;

    state_t      state_q, state_d;
    logic [12:0] cnt_q, cnt_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        we_q, we_d;
    logic [12:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;

    logic        ready;
    logic        accept;
    logic        printable;
    logic        row_adv;
    logic [12:0] row_base;
    logic [12:0] cell_addr;

    assign ready     = (state_q == ST_IDLE);
    assign accept    = bus.char_valid & ready;
    assign printable = (bus.char_i >= CH_BLANK) && (bus.char_i <= CH_TILDE);
    assign row_base  = {3'b000, y_q} * ROW_W;
    assign cell_addr = row_base + {3'b000, x_q};

    assign bus.char_ready = ready;
    assign bus.we_vram    = we_q;
    assign bus.addr_vram  = addr_q;
    assign bus.data_vram  = data_q;
    assign bus.cursor_x   = x_q;
    assign bus.cursor_y   = y_q;

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        row_adv = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (printable) begin
                        we_d   = 1'b1;
                        addr_d = cell_addr;
                        data_d = bus.char_i;
                        if (x_q == X_LAST) begin
                            x_d     = '0;
                            row_adv = 1'b1;
                        end else begin
                            x_d = x_q + 10'd1;
                        end
                    end else if (bus.char_i == CH_LF) begin
                        x_d     = '0;
                        row_adv = 1'b1;
                    end else if (bus.char_i == CH_CR) begin
                        x_d = '0;
                    end else if (bus.char_i == CH_BS) begin
                        if (x_q != '0) begin
                            x_d    = x_q - 10'd1;
                            we_d   = 1'b1;
                            addr_d = cell_addr - 13'd1;
                            data_d = CH_BLANK;
                        end
                    end else if (bus.char_i == CH_FF) begin
                        x_d     = '0;
                        y_d     = '0;
                        cnt_d   = '0;
                        state_d = ST_CLEAR;
                    end
                end
            end

            ST_CLEAR: begin
                we_d   = 1'b1;
                addr_d = cnt_q;
                data_d = CH_BLANK;
                if (cnt_q == CELL_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 13'd1;
                end
            end

            ST_CLRLINE: begin
                we_d   = 1'b1;
                addr_d = row_base + cnt_q;
                data_d = CH_BLANK;
                if (cnt_q == LINE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 13'd1;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_CLEAR;
            end
        endcase

        // No scrolling: falling off the bottom wraps to row 0 and blanks it.
        if (row_adv) begin
            if (y_q < Y_LAST) begin
                y_d = y_q + 10'd1;
            end else begin
                y_d     = '0;
                cnt_d   = '0;
                state_d = ST_CLRLINE;
            end
        end
    end

endmodule

// File: tb/tb_console_writer.sv
// Self-checking bench for console_writer: directed steps plus random code mix,
// checked against a cursor/VRAM-write reference model.
module tb_console_writer;

    localparam int W     = 40;
    localparam int H     = 30;
    localparam int CELLS = W * H;
    localparam int LIMIT = 5000;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    logic px_clk = 1'b0;
    logic rst_n;

    console_writer_if bus();

    console_writer dut (
        .px_clk (px_clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 px_clk = ~px_clk;

    wr_t obs_q[$];
    wr_t exp_q[$];
    int  cyc    = 0;
    int  errors = 0;
    int  checks = 0;
    int  mx     = 0;
    int  my     = 0;

    always @(posedge px_clk) begin
        wr_t w;
        cyc++;
        #1;
        if (bus.we_vram === 1'b1) begin
            w.cyc  = cyc;
            w.addr = int'(bus.addr_vram);
            w.data = int'(bus.data_vram);
            obs_q.push_back(w);
        end
    end

    task automatic chk(input string tag, input logic [31:0] ob, input logic [31:0] ex);
        checks++;
        assert (ob === ex) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, ob, ex);
        end
    endtask

    task automatic push_exp(input int addr, input int data);
        wr_t w;
        w.cyc  = 0;
        w.addr = addr;
        w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic model_row_adv();
        if (my < H - 1) begin
            my++;
        end else begin
            my = 0;
            for (int i = 0; i < W; i++) push_exp(i, 32);
        end
    endtask

    task automatic model_accept(input logic [7:0] c);
        if (c >= 8'h20 && c <= 8'h7E) begin
            push_exp(my * W + mx, int'(c));
            if (mx == W - 1) begin
                mx = 0;
                model_row_adv();
            end else begin
                mx++;
            end
        end else if (c == 8'h0A) begin
            mx = 0;
            model_row_adv();
        end else if (c == 8'h0D) begin
            mx = 0;
        end else if (c == 8'h08) begin
            if (mx > 0) begin
                mx--;
                push_exp(my * W + mx, 32);
            end
        end else if (c == 8'h0C) begin
            mx = 0;
            my = 0;
            for (int i = 0; i < CELLS; i++) push_exp(i, 32);
        end
    endtask

    task automatic send(input logic [7:0] c);
        int n = 0;
        @(negedge px_clk);
        bus.char_i     = c;
        bus.char_valid = 1'b1;
        while (bus.char_ready !== 1'b1 && n < LIMIT) begin
            @(negedge px_clk);
            n++;
        end
        if (n >= LIMIT) begin
            chk("send_timeout", n, 0);
            bus.char_valid = 1'b0;
            return;
        end
        @(posedge px_clk);
        model_accept(c);
        #1 bus.char_valid = 1'b0;
    endtask

    task automatic wait_idle(output int low);
        low = 0;
        @(negedge px_clk);
        while (bus.char_ready !== 1'b1 && low < LIMIT) begin
            low++;
            @(negedge px_clk);
        end
        if (low >= LIMIT) chk("idle_timeout", low, 0);
    endtask

    task automatic check_cursor(input string tag);
        chk({tag, "_cursor_x"}, 32'(bus.cursor_x), mx);
        chk({tag, "_cursor_y"}, 32'(bus.cursor_y), my);
    endtask

    task automatic compare_stream(input string tag, input bit contig);
        int bad = 0;
        int n;
        chk({tag, "_len"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (obs_q[i].addr != exp_q[i].addr || obs_q[i].data != exp_q[i].data) bad++;
        chk({tag, "_bad_writes"}, bad, 0);
        if (contig && obs_q.size() > 0)
            chk({tag, "_contig"}, obs_q[obs_q.size()-1].cyc - obs_q[0].cyc + 1, obs_q.size());
        obs_q.delete();
        exp_q.delete();
    endtask

    function automatic logic [7:0] rnd_print();
        return 8'($urandom_range(32, 126));
    endfunction

    initial begin
        int k;
        int low;
        int r;
        logic [7:0] c;

        // Reset state
        rst_n          = 1'b0;
        bus.char_valid = 1'b0;
        bus.char_i     = 8'h00;
        repeat (3) @(negedge px_clk);
        chk("rst_we",    32'(bus.we_vram),    0);
        chk("rst_addr",  32'(bus.addr_vram),  0);
        chk("rst_data",  32'(bus.data_vram),  0);
        chk("rst_ready", 32'(bus.char_ready), 0);
        check_cursor("rst");

        // Release: full clear while 'A' is held pending
        for (int i = 0; i < CELLS; i++) push_exp(i, 32);
        bus.char_i     = 8'h41;
        bus.char_valid = 1'b1;
        @(negedge px_clk);
        rst_n = 1'b1;
        k     = cyc;
        wait_idle(low);
        chk("clear_ready_cycle", cyc - k, CELLS);
        chk("clear_first_cycle", (obs_q.size() > 0) ? obs_q[0].cyc - k : -1, 1);
        check_cursor("clear_done");
        compare_stream("reset_clear", 1'b1);

        @(posedge px_clk);
        model_accept(8'h41);
        #1 bus.char_valid = 1'b0;
        @(negedge px_clk);
        chk("a_we",   32'(bus.we_vram),   1);
        chk("a_addr", 32'(bus.addr_vram), 0);
        chk("a_data", 32'(bus.data_vram), 32'h41);
        check_cursor("a");
        compare_stream("accept_a", 1'b0);

        // Line wrap: 41 back-to-back printables from (0,0)
        send(8'h0D);
        for (int i = 0; i < 41; i++) send(rnd_print());
        @(negedge px_clk);
        chk("wrap41_addr", 32'(bus.addr_vram), 40);
        check_cursor("wrap41");
        compare_stream("line_wrap", 1'b1);
        send(8'h0D);
        @(negedge px_clk);
        chk("cr_we", 32'(bus.we_vram), 0);
        check_cursor("cr");
        compare_stream("cr_nowrite", 1'b0);

        // Screen wrap: LF at (5,29)
        repeat (28) send(8'h0A);
        repeat (5) send(rnd_print());
        compare_stream("pre_wrap", 1'b0);
        send(8'h0A);
        wait_idle(low);
        chk("wrap_ready_low", low, W);
        check_cursor("screen_wrap");
        compare_stream("screen_wrap", 1'b1);

        // Backspace cases and an ignored code
        send(8'h0A);
        send(8'h0A);
        repeat (3) send(rnd_print());
        compare_stream("pre_bs", 1'b0);
        send(8'h08);
        @(negedge px_clk);
        chk("bs_we",   32'(bus.we_vram),   1);
        chk("bs_addr", 32'(bus.addr_vram), 82);
        chk("bs_data", 32'(bus.data_vram), 32'h20);
        check_cursor("bs");
        compare_stream("bs", 1'b0);
        send(8'h0D);
        send(8'h08);
        send(8'h07);
        @(negedge px_clk);
        chk("bel_ready", 32'(bus.char_ready), 1);
        check_cursor("bs_col0");
        compare_stream("bs_col0_bel", 1'b0);

        // Random code mix
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      c = rnd_print();
            else if (r < 78) c = 8'h0A;
            else if (r < 84) c = 8'h0D;
            else if (r < 92) c = 8'h08;
            else begin
                do c = 8'($urandom_range(0, 255));
                while ((c >= 8'h20 && c <= 8'h7E) || c == 8'h08 || c == 8'h0A ||
                       c == 8'h0C || c == 8'h0D);
            end
            send(c);
        end
        wait_idle(low);
        check_cursor("random");
        compare_stream("random", 1'b0);

        // Full form feed
        send(8'h0C);
        wait_idle(low);
        chk("ff_ready_low", low, CELLS);
        check_cursor("ff");
        compare_stream("ff", 1'b1);

        // Form feed interrupted by reset at write 500
        repeat (3) send(8'h0A);
        repeat (7) send(rnd_print());
        compare_stream("pre_ff", 1'b0);
        send(8'h0C);
        for (int i = 0; i < 3000 && obs_q.size() < 500; i++) begin
            @(posedge px_clk);
            #1;
        end
        chk("ff_writes_before_rst", obs_q.size(), 500);
        @(negedge px_clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_we",    32'(bus.we_vram),    0);
        chk("midrst_addr",  32'(bus.addr_vram),  0);
        chk("midrst_ready", 32'(bus.char_ready), 0);
        while (exp_q.size() > 500) void'(exp_q.pop_back());
        mx = 0;
        my = 0;
        check_cursor("midrst");
        for (int i = 0; i < CELLS; i++) push_exp(i, 32);
        repeat (2) @(negedge px_clk);
        rst_n = 1'b1;
        k     = cyc;
        wait_idle(low);
        chk("rerst_ready_cycle", cyc - k, CELLS);
        chk("rerst_restart_addr", (obs_q.size() > 500) ? obs_q[500].addr : -1, 0);
        chk("rerst_restart_cycle", (obs_q.size() > 500) ? obs_q[500].cyc - k : -1, 1);
        check_cursor("ff_reset");
        compare_stream("ff_reset", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
